// File: rtl/tdc_gpx_pkg.sv
// Shared types and constants for the TDC-GPX register bus engine.
// Holds the bus state encoding, bus widths, direction codes and register addresses.
package tdc_gpx_pkg;

    localparam int TDC_DATA_W = 28;
    localparam int TDC_ADDR_W = 4;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [TDC_ADDR_W-1:0] REG_FIFO0 = 4'd8;
    localparam logic [TDC_ADDR_W-1:0] REG_CTRL4 = 4'd4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOVER
    } bus_state_e;

    // A phase of N cycles is timed by loading N-1 and waiting for zero.
    function automatic logic [3:0] phase_load(input int cycles);
        return 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/tdc_gpx_phase_timer.sv
// Loadable 4-bit down-counter used to time each bus phase.
// o_done is high while the count sits at zero.
module tdc_gpx_phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    output logic       o_done
);

    logic [3:0] r_count;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_done = (r_count == 4'd0);

endmodule

// File: rtl/tdc_gpx_bus_interface.sv
// TDC-GPX parallel register bus engine: one read or write per mem_op, with timed phases.
// Optional macro TDC_BUS_READ_RESYNC_EN adds an input register on tdc_d_i ahead of read capture.
import tdc_gpx_pkg::*;

module tdc_gpx_bus_interface #(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 3,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_op,
    input  logic                  read_write,
    input  logic [TDC_ADDR_W-1:0] addr,
    input  logic [TDC_DATA_W-1:0] data_in,
    output logic                  ready,
    output logic [TDC_DATA_W-1:0] data_out,
    output logic                  data_ready,
    output logic [TDC_ADDR_W-1:0] tdc_adr,
    output logic [TDC_DATA_W-1:0] tdc_d_o,
    output logic                  tdc_d_oe,
    input  logic [TDC_DATA_W-1:0] tdc_d_i,
    output logic                  tdc_csn,
    output logic                  tdc_rdn,
    output logic                  tdc_wrn
);

    localparam logic [3:0] SETUP_LD   = phase_load(SETUP_CYC);
    localparam logic [3:0] STROBE_LD  = phase_load(STROBE_CYC);
    localparam logic [3:0] HOLD_LD    = phase_load(HOLD_CYC);
    localparam logic [3:0] RECOVER_LD = phase_load(RECOVER_CYC);

    bus_state_e            r_state, w_next_state;
    logic                  w_load, w_phase_done, w_accept, w_bus_active;
    logic [3:0]            w_load_val;
    logic                  r_rw;
    logic [TDC_ADDR_W-1:0] r_lat_addr, r_adr;
    logic [TDC_DATA_W-1:0] r_lat_data, r_d_o, r_data_out;
    logic                  r_ready, r_csn, r_rdn, r_wrn, r_d_oe, r_data_ready;
    logic                  w_capture, w_cap_fire;
    logic [TDC_DATA_W-1:0] w_cap_word;

    // Requests are taken only when idle and advertised ready; busy-time strobes are dropped.
    assign w_accept     = mem_op && r_ready && (r_state == IDLE);
    assign w_bus_active = (r_state == SETUP) || (r_state == STROBE) || (r_state == HOLD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rw       <= RW_READ;
            r_lat_addr <= '0;
            r_lat_data <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_rw       <= read_write;
                r_lat_addr <= addr;
                r_lat_data <= data_in;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_val   = '0;
        case (r_state)
            IDLE:    if (w_accept)     begin w_next_state = SETUP;   w_load = 1'b1; w_load_val = SETUP_LD;   end
            SETUP:   if (w_phase_done) begin w_next_state = STROBE;  w_load = 1'b1; w_load_val = STROBE_LD;  end
            STROBE:  if (w_phase_done) begin w_next_state = HOLD;    w_load = 1'b1; w_load_val = HOLD_LD;    end
            HOLD:    if (w_phase_done) begin w_next_state = RECOVER; w_load = 1'b1; w_load_val = RECOVER_LD; end
            RECOVER: if (w_phase_done) begin w_next_state = IDLE; end
            default: w_next_state = IDLE;
        endcase
    end

    tdc_gpx_phase_timer u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_phase_done)
    );

    // Pins are registered from the current state, so they trail the FSM by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready <= 1'b1;
            r_csn   <= 1'b1;
            r_rdn   <= 1'b1;
            r_wrn   <= 1'b1;
            r_d_oe  <= 1'b0;
            r_adr   <= '0;
            r_d_o   <= '0;
        end else begin
            r_ready <= (r_state == IDLE);
            r_csn   <= !w_bus_active;
            r_rdn   <= !((r_state == STROBE) && (r_rw == RW_READ));
            r_wrn   <= !((r_state == STROBE) && (r_rw == RW_WRITE));
            r_d_oe  <= w_bus_active && (r_rw == RW_WRITE);
            if (r_state == SETUP) begin
                r_adr <= r_lat_addr;
                if (r_rw == RW_WRITE) begin
                    r_d_o <= r_lat_data;
                end
            end
        end
    end

    // The read strobe pin is about to rise: this edge closes its last low cycle.
    assign w_capture = !r_rdn && (r_state != STROBE);

`ifdef TDC_BUS_READ_RESYNC_EN
    logic [TDC_DATA_W-1:0] r_d_sync;
    logic                  r_cap_dly;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_d_sync  <= '0;
            r_cap_dly <= 1'b0;
        end else begin
            r_d_sync  <= tdc_d_i;
            r_cap_dly <= w_capture;
        end
    end

    assign w_cap_fire = r_cap_dly;
    assign w_cap_word = r_d_sync;
`else
    assign w_cap_fire = w_capture;
    assign w_cap_word = tdc_d_i;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_out   <= '0;
            r_data_ready <= 1'b0;
        end else begin
            r_data_ready <= w_cap_fire;
            if (w_cap_fire) begin
                r_data_out <= w_cap_word;
            end
        end
    end

    assign ready      = r_ready;
    assign data_out   = r_data_out;
    assign data_ready = r_data_ready;
    assign tdc_adr    = r_adr;
    assign tdc_d_o    = r_d_o;
    assign tdc_d_oe   = r_d_oe;
    assign tdc_csn    = r_csn;
    assign tdc_rdn    = r_rdn;
    assign tdc_wrn    = r_wrn;

endmodule

// File: tb/tb_tdc_gpx_bus_interface.sv
// Bench for tdc_gpx_bus_interface: default-parameter and re-timed instances against a
// cycle-offset reference model, plus directed width/latency measurements.
module tb_tdc_gpx_bus_interface;
    import tdc_gpx_pkg::*;

    localparam int S0 = 1, T0 = 3, H0 = 1, R0 = 2;
    localparam int S1 = 2, T1 = 1, H1 = 3, R1 = 1;
`ifdef TDC_BUS_READ_RESYNC_EN
    localparam int RS = 1;
`else
    localparam int RS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_op     [2] = '{default: 1'b0};
    logic        read_write [2] = '{default: 1'b0};
    logic [3:0]  addr       [2] = '{default: 4'd0};
    logic [27:0] data_in    [2] = '{default: 28'd0};
    logic [27:0] tdc_d_i    [2] = '{default: 28'd0};
    logic        ready      [2];
    logic [27:0] data_out   [2];
    logic        data_ready [2];
    logic [3:0]  tdc_adr    [2];
    logic [27:0] tdc_d_o    [2];
    logic        tdc_d_oe   [2];
    logic        tdc_csn    [2];
    logic        tdc_rdn    [2];
    logic        tdc_wrn    [2];

    always #5 clk = ~clk;

    tdc_gpx_bus_interface #(.SETUP_CYC(S0), .STROBE_CYC(T0), .HOLD_CYC(H0), .RECOVER_CYC(R0)) u_dut0 (
        .clk(clk), .reset(reset), .mem_op(mem_op[0]), .read_write(read_write[0]), .addr(addr[0]),
        .data_in(data_in[0]), .ready(ready[0]), .data_out(data_out[0]), .data_ready(data_ready[0]),
        .tdc_adr(tdc_adr[0]), .tdc_d_o(tdc_d_o[0]), .tdc_d_oe(tdc_d_oe[0]), .tdc_d_i(tdc_d_i[0]),
        .tdc_csn(tdc_csn[0]), .tdc_rdn(tdc_rdn[0]), .tdc_wrn(tdc_wrn[0]));

    tdc_gpx_bus_interface #(.SETUP_CYC(S1), .STROBE_CYC(T1), .HOLD_CYC(H1), .RECOVER_CYC(R1)) u_dut1 (
        .clk(clk), .reset(reset), .mem_op(mem_op[1]), .read_write(read_write[1]), .addr(addr[1]),
        .data_in(data_in[1]), .ready(ready[1]), .data_out(data_out[1]), .data_ready(data_ready[1]),
        .tdc_adr(tdc_adr[1]), .tdc_d_o(tdc_d_o[1]), .tdc_d_oe(tdc_d_oe[1]), .tdc_d_i(tdc_d_i[1]),
        .tdc_csn(tdc_csn[1]), .tdc_rdn(tdc_rdn[1]), .tdc_wrn(tdc_wrn[1]));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Chip read data: each instance answers reads from its own 16-word register image.
    logic [27:0] rd_tab [2][16];

    // ---------------- reference model: outputs as a function of cycles since acceptance
    typedef struct packed {
        logic        ready, csn, rdn, wrn, oe, dr;
        logic [3:0]  adr;
        logic [27:0] d_o, dout;
    } pins_t;

    longint      cyc = 0;
    bit          act  [2] = '{default: 1'b0};
    longint      t0   [2] = '{default: 0};
    logic        rw_m [2] = '{default: 1'b0};
    logic [3:0]  a_m  [2] = '{default: 4'd0};
    logic [27:0] wd_m [2] = '{default: 28'd0};
    logic [27:0] rv_m [2] = '{default: 28'd0};
    logic [3:0]  padr [2] = '{default: 4'd0};
    logic [27:0] pdo  [2] = '{default: 28'd0};
    logic [27:0] pdout[2] = '{default: 28'd0};

    function automatic int p_s(int i); return (i == 0) ? S0 : S1; endfunction
    function automatic int p_t(int i); return (i == 0) ? T0 : T1; endfunction
    function automatic int p_h(int i); return (i == 0) ? H0 : H1; endfunction
    function automatic int p_r(int i); return (i == 0) ? R0 : R1; endfunction

    function automatic bit model_idle(int i);
        return !act[i] || (int'(cyc - t0[i]) > p_s(i) + p_t(i) + p_h(i) + p_r(i));
    endfunction

    function automatic pins_t model_pins(int i);
        pins_t p;
        int d, s, t, h, r, lat;
        s = p_s(i); t = p_t(i); h = p_h(i); r = p_r(i);
        lat = s + t + 1 + RS;
        p.ready = 1'b1; p.csn = 1'b1; p.rdn = 1'b1; p.wrn = 1'b1; p.oe = 1'b0; p.dr = 1'b0;
        p.adr = padr[i]; p.d_o = pdo[i]; p.dout = pdout[i];
        if (act[i]) begin
            d = int'(cyc - t0[i]);
            if (d >= 1 && d <= s + t + h + r) p.ready = 1'b0;
            if (d >= 1 && d <= s + t + h) begin
                p.csn = 1'b0;
                p.oe  = (rw_m[i] == RW_WRITE);
            end
            if (d >= s + 1 && d <= s + t) begin
                if (rw_m[i] == RW_READ) p.rdn = 1'b0;
                else                    p.wrn = 1'b0;
            end
            if (d >= 1) begin
                p.adr = a_m[i];
                if (rw_m[i] == RW_WRITE) p.d_o = wd_m[i];
            end
            if (rw_m[i] == RW_READ && d >= lat) p.dout = rv_m[i];
            p.dr = (rw_m[i] == RW_READ) && (d == lat);
        end
        return p;
    endfunction

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                act[i] = 1'b0; padr[i] = '0; pdo[i] = '0; pdout[i] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (mem_op[i] && model_idle(i)) begin
                    pins_t p;
                    p = model_pins(i);
                    padr[i] = p.adr; pdo[i] = p.d_o; pdout[i] = p.dout;
                    act[i]  = 1'b1;
                    t0[i]   = cyc + 1;
                    rw_m[i] = read_write[i];
                    a_m[i]  = addr[i];
                    wd_m[i] = data_in[i];
                    rv_m[i] = rd_tab[i][addr[i]];
                end
            end
            cyc = cyc + 1;
        end
    end

    // Every-cycle compare of all outputs of both instances against the model.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                pins_t e;
                e = model_pins(i);
                check($sformatf("u%0d.ready", i),      32'(ready[i]),      32'(e.ready));
                check($sformatf("u%0d.csn", i),        32'(tdc_csn[i]),    32'(e.csn));
                check($sformatf("u%0d.rdn", i),        32'(tdc_rdn[i]),    32'(e.rdn));
                check($sformatf("u%0d.wrn", i),        32'(tdc_wrn[i]),    32'(e.wrn));
                check($sformatf("u%0d.d_oe", i),       32'(tdc_d_oe[i]),   32'(e.oe));
                check($sformatf("u%0d.adr", i),        32'(tdc_adr[i]),    32'(e.adr));
                check($sformatf("u%0d.d_o", i),        32'(tdc_d_o[i]),    32'(e.d_o));
                check($sformatf("u%0d.data_out", i),   32'(data_out[i]),   32'(e.dout));
                check($sformatf("u%0d.data_ready", i), 32'(data_ready[i]), 32'(e.dr));
            end
        end
    end

    // Chip model: drives the addressed word while RDN is low, noise otherwise.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            tdc_d_i[i] = (tdc_rdn[i] == 1'b0) ? rd_tab[i][tdc_adr[i]] : 28'($urandom);
    end

    // Bus-cycle log for instance 0: address/data at CSN fall and CSN-high gap before it.
    typedef struct packed { logic [3:0] adr; logic [27:0] d_o; int gap; } mon_t;
    mon_t mon_q[$];
    initial begin
        logic prev_csn;
        int   gap;
        prev_csn = 1'b1;
        gap = 1000;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_csn = 1'b1;
            end else begin
                if (prev_csn && !tdc_csn[0]) begin
                    mon_q.push_back('{adr: tdc_adr[0], d_o: tdc_d_o[0], gap: gap});
                    gap = 0;
                end
                if (tdc_csn[0]) gap++;
                prev_csn = tdc_csn[0];
            end
        end
    end

    // ---------------- stimulus helpers (all called at a falling edge)
    task automatic wait_ready(input int i);
        int k;
        k = 0;
        while (ready[i] !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("u%0d.ready_timeout", i), 32'(ready[i] === 1'b1), 32'd1);
    endtask

    task automatic issue(input int i, input logic rw, input logic [3:0] a, input logic [27:0] wd);
        mem_op[i] = 1'b1; read_write[i] = rw; addr[i] = a; data_in[i] = wd;
        @(negedge clk);
        mem_op[i] = 1'b0;
    endtask

    task automatic run_op(input int i, input logic rw, input logic [3:0] a, input logic [27:0] wd,
                          output int n_csn, output int n_rd, output int n_wr, output int n_oe,
                          output int n_busy, output int n_dr, output int n_pre);
        n_csn = 0; n_rd = 0; n_wr = 0; n_oe = 0; n_busy = 0; n_dr = -1; n_pre = 0;
        wait_ready(i);
        issue(i, rw, a, wd);
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (!tdc_csn[i]) n_csn++;
            if (!tdc_rdn[i]) n_rd++;
            if (!tdc_wrn[i]) n_wr++;
            if (tdc_d_oe[i]) n_oe++;
            if (!tdc_csn[i] && tdc_rdn[i] && tdc_wrn[i] && n_rd == 0 && n_wr == 0) n_pre++;
            if (!ready[i]) n_busy++;
            if (data_ready[i] && n_dr < 0) n_dr = j;
            if (ready[i] && n_busy > 0) break;
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int nc, nr, nw, no, nb, nd, np, base, k;
        logic [3:0]  exp_a [$];
        logic [27:0] exp_d [$];
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 16; j++) rd_tab[i][j] = 28'($urandom);
        rd_tab[0][REG_FIFO0] = 28'hABCDEF1;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset.ready", 32'(ready[0]), 32'd1);
        check("reset.csn",   32'(tdc_csn[0]), 32'd1);
        check("reset.data_out", 32'(data_out[0]), 32'd0);

        // Write to CTRL4
        run_op(0, RW_WRITE, REG_CTRL4, 28'h6400000, nc, nr, nw, no, nb, nd, np);
        check("wr.csn_width", 32'(nc), 32'd5);
        check("wr.wrn_width", 32'(nw), 32'd3);
        check("wr.rdn_width", 32'(nr), 32'd0);
        check("wr.oe_width",  32'(no), 32'd5);
        check("wr.busy",      32'(nb), 32'd7);
        check("wr.no_dready", 32'(nd), 32'hFFFFFFFF);
        check("wr.d_o",       32'(tdc_d_o[0]), 32'h6400000);
        check("wr.adr",       32'(tdc_adr[0]), 32'd4);

        // Read FIFO0
        run_op(0, RW_READ, REG_FIFO0, 28'h0, nc, nr, nw, no, nb, nd, np);
        check("rd.rdn_width", 32'(nr), 32'd3);
        check("rd.wrn_width", 32'(nw), 32'd0);
        check("rd.oe_width",  32'(no), 32'd0);
        check("rd.latency",   32'(nd), 32'(5 + RS));
        check("rd.busy",      32'(nb), 32'd7);
        check("rd.data_out",  32'(data_out[0]), 32'hABCDEF1);

        // mem_op while busy is dropped
        base = mon_q.size();
        wait_ready(0);
        issue(0, RW_WRITE, 4'd3, 28'h1234567);
        repeat (2) @(negedge clk);
        check("busy.ready_low", 32'(ready[0]), 32'd0);
        issue(0, RW_WRITE, 4'd9, 28'h7654321);
        @(negedge clk);
        wait_ready(0);
        repeat (4) @(negedge clk);
        check("busy.one_cycle", 32'(mon_q.size()), 32'(base + 1));
        check("busy.adr",       32'(tdc_adr[0]), 32'd3);
        check("busy.d_o",       32'(tdc_d_o[0]), 32'h1234567);

        // Back-to-back configuration writes from a controller that re-samples ready
        base = mon_q.size();
        for (int n = 0; n < 12; n++) begin
            logic [3:0]  a;
            logic [27:0] d;
            a = 4'($urandom); d = 28'($urandom);
            exp_a.push_back(a); exp_d.push_back(d);
            wait_ready(0);
            issue(0, RW_WRITE, a, d);
            @(negedge clk);
        end
        wait_ready(0);
        check("b2b.count", 32'(mon_q.size() - base), 32'd12);
        for (int n = 0; n < 12 && base + n < mon_q.size(); n++) begin
            check($sformatf("b2b[%0d].adr", n), 32'(mon_q[base+n].adr), 32'(exp_a[n]));
            check($sformatf("b2b[%0d].d_o", n), 32'(mon_q[base+n].d_o), 32'(exp_d[n]));
            if (n > 0) check($sformatf("b2b[%0d].gap_ge2", n), 32'(mon_q[base+n].gap >= 2), 32'd1);
        end

        // Reset during the write strobe
        wait_ready(0);
        issue(0, RW_WRITE, REG_CTRL4, 28'h0F0F0F0);
        k = 0;
        while (tdc_wrn[0] !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        check("rst.reached_strobe", 32'(tdc_wrn[0]), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("rst.wrn",   32'(tdc_wrn[0]),  32'd1);
        check("rst.csn",   32'(tdc_csn[0]),  32'd1);
        check("rst.oe",    32'(tdc_d_oe[0]), 32'd0);
        check("rst.ready", 32'(ready[0]),    32'd1);
        check("rst.adr",   32'(tdc_adr[0]),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op(0, RW_WRITE, 4'd2, 28'h5A5A5A5, nc, nr, nw, no, nb, nd, np);
        check("post_rst.csn_width", 32'(nc), 32'd5);
        check("post_rst.wrn_width", 32'(nw), 32'd3);
        check("post_rst.d_o",       32'(tdc_d_o[0]), 32'h5A5A5A5);

        // Re-timed instance: SETUP=2 STROBE=1 HOLD=3 RECOVER=1
        run_op(1, RW_READ, 4'd5, 28'h0, nc, nr, nw, no, nb, nd, np);
        check("p.setup_width",   32'(np), 32'd2);
        check("p.strobe_width",  32'(nr), 32'd1);
        check("p.hold_width",    32'(nc - np - nr), 32'd3);
        check("p.recover_width", 32'(nb - nc), 32'd1);
        check("p.busy",          32'(nb), 32'd7);
        check("p.latency",       32'(nd), 32'(4 + RS));
        check("p.data_out",      32'(data_out[1]), 32'(rd_tab[1][5]));
        run_op(1, RW_WRITE, 4'd11, 28'h3C3C3C3, nc, nr, nw, no, nb, nd, np);
        check("p.wr_csn_width", 32'(nc), 32'd6);
        check("p.wr_oe_width",  32'(no), 32'd6);
        check("p.wr_wrn_width", 32'(nw), 32'd1);

        // Random request traffic on both instances, including strobes while busy
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 16; j++) rd_tab[i][j] = 28'($urandom);
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                mem_op[i]     = ($urandom_range(0, 3) == 0);
                read_write[i] = 1'($urandom);
                addr[i]       = 4'($urandom);
                data_in[i]    = 28'($urandom);
            end
            @(negedge clk);
        end
        mem_op[0] = 1'b0;
        mem_op[1] = 1'b0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
